// File: rtl/add_seq_pkg.sv
// Shared types and sizing helpers for the
// chunked multi-cycle adder/subtractor.
package add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic int num_chunks(
    input int w,
    input int c
  );
    return w / c;
  endfunction

  function automatic int cnt_width(
    input int n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational W-bit ripple adder; the only
// carry path inside one clock of add_seq.
module add_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, a}
                   + {1'b0, b}
                   + {{W{1'b0}}, cin};

endmodule

// File: rtl/add_seq.sv
// Multi-cycle adder/subtractor: one CHUNK-bit
// slice per clock, LSB first, registered carry.
module add_seq
  import add_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = num_chunks(WIDTH, CHUNK);
  localparam int CW = cnt_width(N);
  localparam int NS = 2 ** CW;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  out_q;
  logic              carry_q;
  logic              cout_q;
  logic              ovf_q;

  logic [CHUNK-1:0]  a_ch [NS];
  logic [CHUNK-1:0]  b_ch [NS];
  logic [CHUNK-1:0]  a_sl;
  logic [CHUNK-1:0]  b_sl;
  logic [CHUNK-1:0]  sum_d;
  logic              carry_d;
  logic              ovf_d;

  // Pad the chunk table to a power of two so
  // every counter value selects a defined entry.
  for (genvar i = 0; i < NS; i++) begin : g_ch
    if (i < N) begin : g_live
      assign a_ch[i] = a_q[i*CHUNK +: CHUNK];
      assign b_ch[i] = b_q[i*CHUNK +: CHUNK];
    end else begin : g_pad
      assign a_ch[i] = '0;
      assign b_ch[i] = '0;
    end
  end

  assign a_sl = a_ch[cnt_q];
  assign b_sl = b_ch[cnt_q];

  add_slice #(
    .W (CHUNK)
  ) u_slice (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry_q),
    .s    (sum_d),
    .cout (carry_d)
  );

  assign ovf_d = (a_sl[CHUNK-1] == b_sl[CHUNK-1])
              && (sum_d[CHUNK-1] != a_sl[CHUNK-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= num1;
            b_q     <= sub ? ~num2 : num2;
            carry_q <= sub | cin;
            out_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          for (int i = 0; i < N; i++) begin
            if (cnt_q == CW'(i)) begin
              out_q[i*CHUNK +: CHUNK] <= sum_d;
            end
          end
          carry_q <= carry_d;
          if (cnt_q == LAST) begin
            cout_q  <= carry_d;
            ovf_q   <= ovf_d;
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_seq.sv
// Scoreboard bench for add_seq at CHUNK=4,
// with CHUNK=16 and CHUNK=1 side instances.
module tb_add_seq;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] o;
    logic         co;
    logic         ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] num1 = '0;
  logic [W-1:0] num2 = '0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;

  logic iv = 1'b0, ir, ova, orr = 1'b0;
  logic [W-1:0] res;
  logic co, ovf;

  logic iv_w = 1'b0, ir_w, ova_w, or_w = 1'b0;
  logic [W-1:0] res_w;
  logic co_w, ovf_w;

  logic iv_b = 1'b0, ir_b, ova_b, or_b = 1'b0;
  logic [W-1:0] res_b;
  logic co_b, ovf_b;

  exp_t sbq[$];
  int n_chk = 0;
  int n_pass = 0;

  add_seq #(.WIDTH(W), .CHUNK(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv), .in_ready(ir),
    .num1(num1), .num2(num2),
    .sub(sub), .cin(cin),
    .out_valid(ova), .out_ready(orr),
    .out(res), .cout(co), .ovf(ovf)
  );

  add_seq #(.WIDTH(W), .CHUNK(16)) u_wide (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv_w), .in_ready(ir_w),
    .num1(num1), .num2(num2),
    .sub(sub), .cin(cin),
    .out_valid(ova_w), .out_ready(or_w),
    .out(res_w), .cout(co_w), .ovf(ovf_w)
  );

  add_seq #(.WIDTH(W), .CHUNK(1)) u_bit (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv_b), .in_ready(ir_b),
    .num1(num1), .num2(num2),
    .sub(sub), .cin(cin),
    .out_valid(ova_b), .out_ready(or_b),
    .out(res_b), .cout(co_b), .ovf(ovf_b)
  );

  function automatic exp_t model(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         s,
    input logic         c
  );
    exp_t e;
    logic [W:0] r;
    logic [W-1:0] bb;
    bb = s ? ~b : b;
    r = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (s | c)};
    e.o = r[W-1:0];
    e.co = r[W];
    e.ov = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic send(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         s,
    input logic         c,
    input exp_t         e
  );
    @(negedge clk);
    num1 = a; num2 = b; sub = s; cin = c;
    iv = 1'b1;
    sbq.push_back(e);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!ova && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out;
    @(negedge clk);
    orr = 1'b1;
    @(posedge clk); #1;
    orr = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    n_chk++; if (ir !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", ir); else n_pass++;
    n_chk++; if (ova !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", ova); else n_pass++;
    n_chk++; if (res !== '0) $display("FAIL rst_out got %h exp 0000", res); else n_pass++;
    n_chk++; if ({co, ovf} !== 2'b00) $display("FAIL rst_flags got %b exp 00", {co, ovf}); else n_pass++;
    n_chk++; if ({ir_w, ir_b} !== 2'b11) $display("FAIL rst_side_ready got %b exp 11", {ir_w, ir_b}); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    logic [W-1:0] ta [6] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0000};
    logic [W-1:0] tb [6] = '{16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0000};
    logic         ts [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic         tc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] to [6] = '{16'h0100, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h0001};
    logic         tco[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic         tov[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_t e;
    int lat;
    for (int i = 0; i < 6; i++) begin
      e.o = to[i]; e.co = tco[i]; e.ov = tov[i];
      send(ta[i], tb[i], ts[i], tc[i], e);
      @(posedge clk); #1;
      iv = 1'b0;
      n_chk++; if (ir !== 1'b0) $display("FAIL add_accept[%0d] in_ready got %b exp 0", i, ir); else n_pass++;
      wait_out(lat);
      n_chk++; if (lat != 4) $display("FAIL add_latency[%0d] got %0d exp 4", i, lat); else n_pass++;
      e = sbq.pop_front();
      n_chk++; if (res !== e.o) $display("FAIL add_out[%0d] got %h exp %h", i, res, e.o); else n_pass++;
      n_chk++; if (co !== e.co) $display("FAIL add_cout[%0d] got %b exp %b", i, co, e.co); else n_pass++;
      n_chk++; if (ovf !== e.ov) $display("FAIL add_ovf[%0d] got %b exp %b", i, ovf, e.ov); else n_pass++;
      release_out();
      n_chk++; if ({ir, ova} !== 2'b10) $display("FAIL add_release[%0d] ready/valid got %b exp 10", i, {ir, ova}); else n_pass++;
    end
  endtask

  task automatic test_hold;
    exp_t e;
    int lat;
    send(16'h1234, 16'h0F0F, 1'b0, 1'b0, model(16'h1234, 16'h0F0F, 1'b0, 1'b0));
    @(posedge clk); #1;
    iv = 1'b0;
    wait_out(lat);
    n_chk++; if (lat != 4) $display("FAIL hold_latency got %0d exp 4", lat); else n_pass++;
    e = sbq.pop_front();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      iv = 1'b1;
      num1 = 16'($urandom);
      num2 = 16'($urandom);
      sub = 1'($urandom);
      cin = 1'($urandom);
      @(posedge clk); #1;
      n_chk++; if (res !== e.o) $display("FAIL hold_out[%0d] got %h exp %h", k, res, e.o); else n_pass++;
      n_chk++; if ({co, ovf} !== {e.co, e.ov}) $display("FAIL hold_flags[%0d] got %b exp %b", k, {co, ovf}, {e.co, e.ov}); else n_pass++;
      n_chk++; if ({ir, ova} !== 2'b01) $display("FAIL hold_hs[%0d] ready/valid got %b exp 01", k, {ir, ova}); else n_pass++;
    end
    @(negedge clk);
    orr = 1'b1;
    num1 = 16'hAAAA; num2 = 16'h1111; sub = 1'b0; cin = 1'b0;
    sbq.push_back(model(16'hAAAA, 16'h1111, 1'b0, 1'b0));
    @(posedge clk); #1;
    orr = 1'b0;
    n_chk++; if ({ir, ova} !== 2'b10) $display("FAIL hold_release ready/valid got %b exp 10", {ir, ova}); else n_pass++;
    @(posedge clk); #1;
    iv = 1'b0;
    n_chk++; if (ir !== 1'b0) $display("FAIL hold_next_accept in_ready got %b exp 0", ir); else n_pass++;
    wait_out(lat);
    n_chk++; if (lat != 4) $display("FAIL hold_next_latency got %0d exp 4", lat); else n_pass++;
    e = sbq.pop_front();
    n_chk++; if (res !== e.o) $display("FAIL hold_next_out got %h exp %h", res, e.o); else n_pass++;
    release_out();
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int lat;
    @(negedge clk);
    num1 = 16'h0FFF; num2 = 16'h0111; sub = 1'b0; cin = 1'b0;
    iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_chk++; if (ova !== 1'b0) $display("FAIL midrst_valid got %b exp 0", ova); else n_pass++;
    n_chk++; if (res !== '0) $display("FAIL midrst_out got %h exp 0000", res); else n_pass++;
    n_chk++; if ({co, ovf} !== 2'b00) $display("FAIL midrst_flags got %b exp 00", {co, ovf}); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++; if (ir !== 1'b1) $display("FAIL midrst_ready got %b exp 1", ir); else n_pass++;
    e.o = 16'h2345; e.co = 1'b0; e.ov = 1'b0;
    send(16'h1234, 16'h1111, 1'b0, 1'b0, e);
    @(posedge clk); #1;
    iv = 1'b0;
    wait_out(lat);
    n_chk++; if (lat != 4) $display("FAIL midrst_latency got %0d exp 4", lat); else n_pass++;
    e = sbq.pop_front();
    n_chk++; if ({res, co, ovf} !== e) $display("FAIL midrst_result got %h/%b/%b exp %h/%b/%b", res, co, ovf, e.o, e.co, e.ov); else n_pass++;
    release_out();
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int lat;
    logic [W-1:0] a, b;
    logic s, c;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      s = 1'($urandom); c = 1'($urandom);
      send(a, b, s, c, model(a, b, s, c));
      @(posedge clk); #1;
      iv = 1'b0;
      wait_out(lat);
      n_chk++; if (lat != 4) $display("FAIL b2b_latency[%0d] got %0d exp 4", i, lat); else n_pass++;
      e = sbq.pop_front();
      n_chk++; if ({res, co, ovf} !== e) $display("FAIL b2b_result[%0d] got %h/%b/%b exp %h/%b/%b", i, res, co, ovf, e.o, e.co, e.ov); else n_pass++;
      release_out();
    end
  endtask

  task automatic test_widths;
    logic [W-1:0] va [2] = '{16'h0000, 16'h8000};
    logic [W-1:0] vb [2] = '{16'h0000, 16'h0001};
    logic         vs [2] = '{1'b0, 1'b1};
    logic         vc [2] = '{1'b1, 1'b0};
    exp_t e;
    int lat;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      num1 = va[i]; num2 = vb[i]; sub = vs[i]; cin = vc[i];
      iv_w = 1'b1;
      sbq.push_back(model(va[i], vb[i], vs[i], vc[i]));
      @(posedge clk); #1;
      iv_w = 1'b0;
      lat = 0;
      while (!ova_w && lat < 64) begin
        @(posedge clk); #1;
        lat++;
      end
      n_chk++; if (lat != 1) $display("FAIL wide_latency[%0d] got %0d exp 1", i, lat); else n_pass++;
      e = sbq.pop_front();
      n_chk++; if ({res_w, co_w, ovf_w} !== e) $display("FAIL wide_result[%0d] got %h/%b/%b exp %h/%b/%b", i, res_w, co_w, ovf_w, e.o, e.co, e.ov); else n_pass++;
      @(negedge clk); or_w = 1'b1;
      @(posedge clk); #1; or_w = 1'b0;

      @(negedge clk);
      iv_b = 1'b1;
      sbq.push_back(model(va[i], vb[i], vs[i], vc[i]));
      @(posedge clk); #1;
      iv_b = 1'b0;
      lat = 0;
      while (!ova_b && lat < 64) begin
        @(posedge clk); #1;
        lat++;
      end
      n_chk++; if (lat != 16) $display("FAIL bit_latency[%0d] got %0d exp 16", i, lat); else n_pass++;
      e = sbq.pop_front();
      n_chk++; if ({res_b, co_b, ovf_b} !== e) $display("FAIL bit_result[%0d] got %h/%b/%b exp %h/%b/%b", i, res_b, co_b, ovf_b, e.o, e.co, e.ov); else n_pass++;
      @(negedge clk); or_b = 1'b1;
      @(posedge clk); #1; or_b = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_widths();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/add_seq.md
# add_seq

Parametrised multi-cycle adder/subtractor that resolves a WIDTH-bit sum CHUNK bits per clock, LSB chunk first, through a registered carry. It replaces the fixed-width single-cycle ripple adder where wide operands would break timing. It sits between a valid/ready producer and consumer in the datapath. Results carry carry-out and signed-overflow flags.

## Interface
- WIDTH, 16, operand and result width; must be a multiple of CHUNK.
- CHUNK, 4, bits resolved per cycle; 1 ≤ CHUNK ≤ WIDTH.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept; high only in IDLE.
- num1  in  WIDTH  operand A.
- num2  in  WIDTH  operand B.
- sub  in  1  0 = A+B+cin, 1 = A−B (cin ignored).
- cin  in  1  carry-in for add.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out  out  WIDTH  result.
- cout  out  1  final carry; for sub, 1 = no borrow.
- ovf  out  1  two's-complement overflow.

## Operation
- N = WIDTH/CHUNK chunks; counter width max(1, clog2(N)).
- FSM: IDLE → BUSY on in_valid && in_ready; BUSY → DONE after chunk N−1; DONE → IDLE on out_ready.
- Accept: latch A = num1, B' = sub ? ~num2 : num2, carry = sub ? 1 : cin; clear out, cout, ovf.
- BUSY cycle k (k = 0..N−1): out[k*CHUNK +: CHUNK] ← A_k + B'_k + carry; carry ← chunk carry-out.
- Final chunk also sets cout ← carry-out and ovf ← (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]).
- Input changes outside the accept edge are ignored. in_valid during BUSY/DONE is not accepted.
- DONE: out, cout, ovf, out_valid held stable until out_ready is high on a rising edge.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset (asynchronous, immediate): state IDLE, out = 0, cout = 0, ovf = 0, out_valid = 0, counter = 0. in_ready = 1 from IDLE.
- Reset mid-operation discards the in-flight op. No partial result is ever flagged valid.
- Latency: accept at edge E → out_valid rises at edge E+N.
- in_ready and out_valid are decoded from registered state only, with no combinational path from inputs.
- Output handshake at edge F → in_ready high after F. Next accept is no earlier than edge F+1. Minimum initiation interval is N+1 cycles.
- CHUNK == WIDTH: N = 1, single BUSY cycle.
- Carry chain from one chunk to the next is broken only by the carry register. Critical path = one CHUNK-bit ripple.

## Structure
- Shared package: FSM state enum (IDLE, BUSY, DONE). It also holds a localparam helper for N and counter width.
- One sub-module: add_slice, a combinational CHUNK-bit ripple adder with ports a, b, cin, s, cout. It is instantiated once and muxed by the chunk counter.
- Top level holds the FSM, counter, operand/carry registers and result register.

## Test plan
- WIDTH=16, CHUNK=4, add 0x00FF + 0x0001, cin=0 → out=0x0100, cout=0, ovf=0, out_valid exactly 4 edges after accept.
- Add 0xFFFF + 0x0001 → 0x0000, cout=1, ovf=0. Add 0x7FFF + 0x0001 → 0x8000, cout=0, ovf=1.
- Sub 0x0005 − 0x0007 → 0xFFFE, cout=0, ovf=0. Sub 0x8000 − 0x0001 → 0x7FFF, cout=1, ovf=1.
- Hold out_ready=0 for 5 cycles in DONE with in_valid=1 and changing operands → out, cout, ovf unchanged, in_ready=0, nothing accepted. Then out_ready=1 → next op accepted one edge later.
- Assert rst_n low during chunk 2 → out_valid, out, cout, ovf = 0 immediately, and in_ready=1 after release. Next op 0x1234 + 0x1111 → 0x2345.
- Cin case: 0x0000 + 0x0000 with cin=1 → 0x0001. Repeat with CHUNK=16 → out_valid 1 edge after accept. Repeat with CHUNK=1 → out_valid 16 edges after accept.
